// File: rtl/ps2_key_pkg.sv
// Scan-code constants, arrow encodings and parser states shared by the PS/2 key arbiter.
package ps2_key_pkg;

  localparam logic [7:0] SC_EXT      = 8'hE0;
  localparam logic [7:0] SC_BRK      = 8'hF0;
  localparam logic [7:0] SC_P1_UP    = 8'h1D;
  localparam logic [7:0] SC_P1_LEFT  = 8'h1C;
  localparam logic [7:0] SC_P1_DOWN  = 8'h1B;
  localparam logic [7:0] SC_P1_RIGHT = 8'h23;
  localparam logic [7:0] SC_P2_UP    = 8'h75;
  localparam logic [7:0] SC_P2_LEFT  = 8'h6B;
  localparam logic [7:0] SC_P2_DOWN  = 8'h72;
  localparam logic [7:0] SC_P2_RIGHT = 8'h74;

  localparam logic [2:0] ARROW_NONE  = 3'b000;
  localparam logic [2:0] ARROW_UP    = 3'b001;
  localparam logic [2:0] ARROW_LEFT  = 3'b010;
  localparam logic [2:0] ARROW_DOWN  = 3'b011;
  localparam logic [2:0] ARROW_RIGHT = 3'b100;

  typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK} parse_state_e;

  function automatic logic [2:0] p1_map(input logic [7:0] code);
    case (code)
      SC_P1_UP:    return ARROW_UP;
      SC_P1_LEFT:  return ARROW_LEFT;
      SC_P1_DOWN:  return ARROW_DOWN;
      SC_P1_RIGHT: return ARROW_RIGHT;
      default:     return ARROW_NONE;
    endcase
  endfunction

  function automatic logic [2:0] p2_map(input logic [7:0] code);
    case (code)
      SC_P2_UP:    return ARROW_UP;
      SC_P2_LEFT:  return ARROW_LEFT;
      SC_P2_DOWN:  return ARROW_DOWN;
      SC_P2_RIGHT: return ARROW_RIGHT;
      default:     return ARROW_NONE;
    endcase
  endfunction

  // Held-bit mask {right, down, left, up} for an arrow code; zero for ARROW_NONE.
  function automatic logic [3:0] arrow_mask(input logic [2:0] arrow);
    return (arrow == ARROW_NONE) ? 4'b0000 : (4'b0001 << (arrow - 3'd1));
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Small synchronous FIFO of 3-bit arrow events with sticky overflow on dropped pushes.
module key_event_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [2:0] data_in,
  output logic       valid,
  output logic [2:0] head,
  output logic       full,
  output logic       overflow
);
  localparam int AW = $clog2(DEPTH);

  logic [2:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign valid   = (count != '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && valid;
  // A pop on a full queue frees the slot the simultaneous push needs.
  assign do_push = push && (!full || do_pop);
  assign head    = valid ? mem[rd_ptr] : 3'b000;

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !do_push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= data_in;
  end

endmodule

// File: rtl/ps2_key_arbiter.sv
// Parses the PS/2 byte stream into per-player arrow press events and queues them for each processor.
module ps2_key_arbiter
  import ps2_key_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter bit DROP_REPEAT = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_key_pressed,
  input  logic [7:0] ps2_key_data,
  output logic       p1_valid,
  output logic [2:0] p1_arrow,
  input  logic       p1_ack,
  output logic       p2_valid,
  output logic [2:0] p2_arrow,
  input  logic       p2_ack,
  output logic [3:0] p1_held,
  output logic [3:0] p2_held,
  output logic       p1_overflow,
  output logic       p2_overflow
);

  parse_state_e state, state_nxt;
  logic         is_make, is_brk, is_ext, is_prefix;
  logic [2:0]   p1_code, p2_code;
  logic [3:0]   p1_mask, p2_mask;
  logic         p1_push, p2_push;
  logic         p1_full, p2_full;

  assign is_prefix = (ps2_key_data == SC_EXT) || (ps2_key_data == SC_BRK);

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (ps2_key_pressed) begin
      case (state)
        ST_IDLE: begin
          if (ps2_key_data == SC_EXT)      state_nxt = ST_EXT;
          else if (ps2_key_data == SC_BRK) state_nxt = ST_BRK;
          else                             state_nxt = ST_IDLE;
        end
        ST_EXT:  state_nxt = (ps2_key_data == SC_BRK) ? ST_EXT_BRK : ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Prefix bytes arriving where a key byte is expected are dropped as unknown keys.
  always_comb begin
    is_make = 1'b0;
    is_brk  = 1'b0;
    is_ext  = 1'b0;
    if (ps2_key_pressed) begin
      case (state)
        ST_IDLE:    is_make = !is_prefix;
        ST_EXT:     begin is_make = (ps2_key_data != SC_BRK); is_ext = 1'b1; end
        ST_BRK:     is_brk  = !is_prefix;
        ST_EXT_BRK: begin is_brk = !is_prefix; is_ext = 1'b1; end
        default:    ;
      endcase
    end
  end

  assign p1_code = is_ext ? ARROW_NONE : p1_map(ps2_key_data);
  assign p2_code = p2_map(ps2_key_data);
  assign p1_mask = arrow_mask(p1_code);
  assign p2_mask = arrow_mask(p2_code);

  assign p1_push = is_make && (p1_code != ARROW_NONE) && !(DROP_REPEAT && ((p1_held & p1_mask) != 4'b0000));
  assign p2_push = is_make && (p2_code != ARROW_NONE) && !(DROP_REPEAT && ((p2_held & p2_mask) != 4'b0000));

  always_ff @(posedge clock) begin
    if (reset) begin
      p1_held <= 4'b0000;
      p2_held <= 4'b0000;
    end else if (is_make) begin
      p1_held <= p1_held | p1_mask;
      p2_held <= p2_held | p2_mask;
    end else if (is_brk) begin
      p1_held <= p1_held & ~p1_mask;
      p2_held <= p2_held & ~p2_mask;
    end
  end

  key_event_fifo #(.DEPTH(FIFO_DEPTH)) u_p1_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (p1_push),
    .pop      (p1_ack),
    .data_in  (p1_code),
    .valid    (p1_valid),
    .head     (p1_arrow),
    .full     (p1_full),
    .overflow (p1_overflow)
  );

  key_event_fifo #(.DEPTH(FIFO_DEPTH)) u_p2_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (p2_push),
    .pop      (p2_ack),
    .data_in  (p2_code),
    .valid    (p2_valid),
    .head     (p2_arrow),
    .full     (p2_full),
    .overflow (p2_overflow)
  );

endmodule

// File: doc/ps2_key_arbiter.md
Name: ps2_key_arbiter

Overview:
- Sits between the shared PS2_Interface and the two processor instances.
- Parses the raw PS/2 scan-code byte stream: make, break and E0-extended prefixes.
- Classifies each key as a player-1 or player-2 arrow, suppresses typematic repeats, and queues each event in a per-player FIFO.
- Each processor drains its own FIFO through a valid/ack handshake. This replaces the combinational equality decode, which cannot tell press from release or from auto-repeat.

Parameters:
- FIFO_DEPTH, 4, entries per player queue; power of two, minimum 2.
- DROP_REPEAT, 1, when 1 a make code for a key already held is not enqueued.

Ports:
- clock  input  1  system clock (10 MHz domain, same as the processors).
- reset  input  1  synchronous, active-high.
- ps2_key_pressed  input  1  one-cycle strobe: a new byte is on ps2_key_data.
- ps2_key_data  input  8  received scan-code byte.
- p1_valid  output  1  player-1 FIFO non-empty.
- p1_arrow  output  3  player-1 head event: 001 up, 010 left, 011 down, 100 right.
- p1_ack  input  1  pop the player-1 head.
- p2_valid  output  1  player-2 FIFO non-empty.
- p2_arrow  output  3  player-2 head event, same encoding.
- p2_ack  input  1  pop the player-2 head.
- p1_held  output  4  player-1 key-down state, bits {right, down, left, up}.
- p2_held  output  4  player-2 key-down state, same bit order.
- p1_overflow  output  1  sticky: a player-1 event was dropped because the FIFO was full.
- p2_overflow  output  1  sticky: same, player 2.

Behaviour:
- Reset values:
  - All outputs are 0; p*_arrow is 000 when its FIFO is empty.
  - FIFOs are flushed, parser is in IDLE, held bits cleared, overflow flags cleared.
  - Reset asserted mid-sequence (for example after F0 but before the key byte) discards the partial sequence.
- Parser FSM advances only on cycles with ps2_key_pressed=1. States: IDLE, EXT, BRK, EXT_BRK.
  - IDLE: E0 goes to EXT; F0 goes to BRK; any other byte is a non-extended make code, processed, and the FSM stays in IDLE.
  - EXT: F0 goes to EXT_BRK; any other byte is an extended make code, processed, then IDLE.
  - BRK: the byte is a non-extended break code, processed, then IDLE.
  - EXT_BRK: the byte is an extended break code, processed, then IDLE.
  - E0 or F0 arriving in BRK or EXT_BRK is treated as an unknown key byte: ignored, return to IDLE.
- Key map:
  - Player 1, non-extended only: 1D up, 1C left, 1B down, 23 right.
  - Player 2, extended or non-extended (arrow keys or keypad 8/4/2/6): 75 up, 6B left, 72 down, 74 right.
  - Player-1 codes arriving with an E0 prefix are ignored. All unmapped codes are ignored.
- Make event:
  - If DROP_REPEAT=1 and the held bit is already 1, there is no push.
  - Otherwise the arrow code is pushed. The held bit is set in both cases.
- Break event: clears the held bit; nothing is enqueued.
- Latency:
  - The strobe carrying the final byte of a sequence at edge N updates the FIFO at edge N, so p*_valid is 1 in the following cycle (FIFO previously empty).
  - p*_held updates on the same edge.
- Handshake:
  - p*_ack while p*_valid=1 pops the head at that edge.
  - p*_ack while p*_valid=0 is ignored; no underflow.
  - p*_arrow is stable while valid=1 and ack=0.
- Full FIFO:
  - A push without a simultaneous pop is dropped and p*_overflow is set (it clears only on reset); the FIFO contents are unchanged.
  - Push and pop in the same cycle are both performed, whether the FIFO is full, partial or holding one entry; the count is unchanged.
  - A push and pop on an empty FIFO: the push completes and no pop occurs.
- The two players are fully independent. At most one byte arrives per cycle, so at most one push in total occurs per cycle.
- Pointers are log2(FIFO_DEPTH) bits, wrap modulo FIFO_DEPTH, and are paired with a (log2+1)-bit count.

Decomposition:
- Package ps2_key_pkg holds:
  - scan-code constants (E0, F0, 1D, 1C, 1B, 23, 75, 6B, 72, 74);
  - arrow encodings (ARROW_UP=3'b001, ARROW_LEFT=3'b010, ARROW_DOWN=3'b011, ARROW_RIGHT=3'b100);
  - the parser-state enumeration.
- One sub-module, key_event_fifo: 3-bit synchronous FIFO with push, pop, valid, head, full and overflow, parameterised by depth. It is instantiated twice.
- The parser and classification logic stay in the top module.

Test Plan:
- Player-1 tap: bytes 1D, then F0 1D, no ack -> p1_valid=1 with p1_arrow=001; p1_held is 0001 after 1D and 0000 after F0 1D; p2_valid stays 0.
- Typematic: bytes E0 75, E0 75, E0 75, then E0 F0 75 -> exactly one p2 entry (001); p2_held[0]=1 until the break. Repeat with DROP_REPEAT=0 -> three entries.
- Overflow: six distinct player-1 makes (1D 1C 1B 23 1D 1C, each followed by its break), no ack -> 4 entries held in the order 001 010 011 100, p1_overflow=1. Four acks drain in order; the fifth ack is ignored and p1_valid=0.
- Full with simultaneous push and ack: the push is accepted, the head advances, the count stays 4, and the overflow flag is not set.
- Prefix handling:
  - E0 1D -> no push.
  - Bytes E0 followed by 12 (unmapped) -> ignored, parser back to IDLE; a following 1C pushes 010 for player 1.
  - F0 E0 -> ignored, parser back to IDLE.
- Reset between F0 and 1B (after an earlier make 1B) -> FIFOs empty, held=0000; the next byte 1B is treated as a make code and pushes 011.
